// File: rtl/tic_tac_toe_pkg.sv
// tic_tac_toe_pkg: shared state, winner codes and line geometry for the game controller
package tic_tac_toe_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_MOVE, CHECK, DONE} state_t;
  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_BLUE = 2'b01;
  localparam logic [1:0] WINNER_YELLOW = 2'b10;
  localparam logic [1:0] WINNER_DRAW = 2'b11;
  localparam int NUM_SQUARES = 9;
  // rows, then columns, then the two diagonals; index order matches win_line bits
  localparam logic [3:0] LINES [8][3] = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
  };
endpackage

// File: rtl/win_detect.sv
// win_detect: flags every line fully owned by the given colour
module win_detect
  import tic_tac_toe_pkg::*;
(
  input  logic [NUM_SQUARES-1:0] square_en,
  input  logic [NUM_SQUARES-1:0] square_color,
  input  logic                   colour,
  output logic [7:0]             line_hit
);
  logic [NUM_SQUARES-1:0] mine;
  assign mine = square_en & (colour ? square_color : ~square_color);
  for (genvar l = 0; l < 8; l++) begin : g_line
    assign line_hit[l] = mine[LINES[l][0]] & mine[LINES[l][1]] & mine[LINES[l][2]];
  end
endmodule

// File: rtl/board_ctrl.sv
// board_ctrl: tic-tac-toe sequencing, board state and win/draw judgement
module board_ctrl
  import tic_tac_toe_pkg::*;
#(
  parameter logic FIRST_PLAYER = 1'b0
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic                   start_en,
  input  logic                   choice_en,
  input  logic                   new_game,
  input  logic                   sel_valid,
  input  logic [3:0]             sel_idx,
  output logic                   sel_ack,
  output logic                   sel_reject,
  output logic [NUM_SQUARES-1:0] square_en,
  output logic [NUM_SQUARES-1:0] square_color,
  output logic                   player,
  output logic                   game_over,
  output logic [1:0]             winner,
  output logic [7:0]             win_line
);
  state_t state;
  logic [3:0] move_cnt;
  logic ng_pend, do_clear;
  logic [15:0] blocked;
  logic [NUM_SQUARES-1:0] pick;
  logic [7:0] line_hit;
  // indices 9..15 are permanently blocked so one lookup covers invalid and occupied
  always_comb begin
    blocked = {7'h7f, square_en};
    pick = NUM_SQUARES'(1) << sel_idx;
    do_clear = !start_en || ((new_game || ng_pend) && (state == WAIT_MOVE || state == DONE));
  end
  win_detect u_win (
    .square_en(square_en),
    .square_color(square_color),
    .colour(player),
    .line_hit(line_hit)
  );
  always_ff @(posedge pclk) begin
    if (rst || do_clear) begin
      state <= (!rst && start_en && !choice_en) ? WAIT_MOVE : IDLE;
      square_en <= '0;
      square_color <= '0;
      player <= FIRST_PLAYER;
      game_over <= 1'b0;
      winner <= WINNER_NONE;
      win_line <= '0;
      sel_ack <= 1'b0;
      sel_reject <= 1'b0;
      move_cnt <= '0;
      ng_pend <= 1'b0;
    end else begin
      sel_ack <= 1'b0;
      sel_reject <= 1'b0;
      ng_pend <= (state == CHECK) && new_game;
      case (state)
        IDLE: if (!choice_en) state <= WAIT_MOVE;
        WAIT_MOVE: if (sel_valid && !choice_en) begin
          if (blocked[sel_idx]) sel_reject <= 1'b1;
          else begin
            square_en <= square_en | pick;
            square_color <= player ? (square_color | pick) : square_color;
            move_cnt <= move_cnt + 4'd1;
            sel_ack <= 1'b1;
            state <= CHECK;
          end
        end
        CHECK: if (|line_hit) begin
          winner <= player ? WINNER_YELLOW : WINNER_BLUE;
          win_line <= line_hit;
          game_over <= 1'b1;
          state <= DONE;
        end else if (move_cnt == 4'd9) begin
          winner <= WINNER_DRAW;
          game_over <= 1'b1;
          state <= DONE;
        end else begin
          player <= ~player;
          state <= WAIT_MOVE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_board_ctrl.sv
// tb_board_ctrl: directed and randomized games checked against a board-level reference model
module tb_board_ctrl;
  logic pclk = 1'b0;
  logic rst, start_en, choice_en, new_game, sel_valid;
  logic [3:0] sel_idx;
  logic sel_ack, sel_reject, player, game_over;
  logic [8:0] square_en, square_color;
  logic [1:0] winner;
  logic [7:0] win_line;

  board_ctrl dut (
    .pclk(pclk), .rst(rst), .start_en(start_en), .choice_en(choice_en),
    .new_game(new_game), .sel_valid(sel_valid), .sel_idx(sel_idx),
    .sel_ack(sel_ack), .sel_reject(sel_reject), .square_en(square_en),
    .square_color(square_color), .player(player), .game_over(game_over),
    .winner(winner), .win_line(win_line)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0, n_fail = 0;
  int board[9];
  int turn, cnt;
  bit over, idle;
  logic [1:0] m_winner;
  logic [7:0] m_line;
  logic got_ack, got_rej, exp_ack, exp_rej;

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  function automatic int sq(input int l, input int k);
    if (l < 3) return l * 3 + k;
    if (l < 6) return (l - 3) + 3 * k;
    if (l == 6) return 4 * k;
    return 2 + 2 * k;
  endfunction

  function automatic logic [8:0] m_en();
    logic [8:0] v = '0;
    for (int i = 0; i < 9; i++) v[i] = (board[i] != 0);
    return v;
  endfunction

  function automatic logic [8:0] m_col();
    logic [8:0] v = '0;
    for (int i = 0; i < 9; i++) v[i] = (board[i] == 2);
    return v;
  endfunction

  task automatic model_clear;
    for (int i = 0; i < 9; i++) board[i] = 0;
    turn = 0; cnt = 0; over = 0; m_winner = 2'b00; m_line = '0;
  endtask

  task automatic model_place(input int idx);
    int me;
    me = turn + 1;
    board[idx] = me;
    cnt++;
    m_line = '0;
    for (int l = 0; l < 8; l++)
      m_line[l] = board[sq(l, 0)] == me && board[sq(l, 1)] == me && board[sq(l, 2)] == me;
    if (m_line != 0) begin m_winner = 2'(me); over = 1; end
    else if (cnt == 9) begin m_winner = 2'b11; over = 1; end
    else turn ^= 1;
  endtask

  // presents one selection; accepted moves also wait out the judging cycle
  task automatic play(input int idx, input bit ch);
    sel_idx = 4'(idx); sel_valid = 1; choice_en = ch;
    tick;
    sel_valid = 0; choice_en = 0;
    got_ack = sel_ack; got_rej = sel_reject;
    exp_ack = 0; exp_rej = 0;
    if (!ch && !over && !idle) begin
      if (idx > 8 || board[idx] != 0) exp_rej = 1;
      else begin exp_ack = 1; model_place(idx); tick; end
    end
  endtask

  task automatic pulse_new_game;
    new_game = 1;
    tick;
    new_game = 0;
    model_clear;
  endtask

  task automatic test_reset;
    rst = 1; start_en = 0; choice_en = 0; new_game = 0; sel_valid = 0; sel_idx = 0;
    tick; tick;
    n_checks++; if ({square_en, square_color} !== 18'h0) begin n_fail++; $display("FAIL reset_board got %h exp 0", {square_en, square_color}); end
    n_checks++; if ({player, game_over, winner, win_line} !== 12'h0) begin n_fail++; $display("FAIL reset_status got %h exp 0", {player, game_over, winner, win_line}); end
    n_checks++; if ({sel_ack, sel_reject} !== 2'b00) begin n_fail++; $display("FAIL reset_handshake got %b exp 00", {sel_ack, sel_reject}); end
    rst = 0; start_en = 1;
    tick;
    model_clear; idle = 0;
    n_checks++; if ({square_en, player, winner} !== 12'h0) begin n_fail++; $display("FAIL start_clear got %h exp 0", {square_en, player, winner}); end
  endtask

  task automatic test_row_win;
    int seq[5] = '{0, 3, 1, 4, 2};
    foreach (seq[i]) begin
      play(seq[i], 0);
      n_checks++; if ({got_ack, got_rej} !== 2'b10) begin n_fail++; $display("FAIL row_ack move %0d got %b exp 10", i, {got_ack, got_rej}); end
    end
    n_checks++; if ({winner, win_line, game_over} !== {2'b01, 8'h01, 1'b1}) begin n_fail++; $display("FAIL row_result got %h exp %h", {winner, win_line, game_over}, {2'b01, 8'h01, 1'b1}); end
    n_checks++; if ({square_en, square_color} !== {9'h01F, 9'h018}) begin n_fail++; $display("FAIL row_board got %h exp %h", {square_en, square_color}, {9'h01F, 9'h018}); end
    play(5, 0);
    n_checks++; if ({got_ack, got_rej, square_en} !== {2'b00, 9'h01F}) begin n_fail++; $display("FAIL done_ignores got %h exp %h", {got_ack, got_rej, square_en}, {2'b00, 9'h01F}); end
    pulse_new_game;
    n_checks++; if ({square_en, square_color, player, game_over, winner, win_line} !== '0) begin n_fail++; $display("FAIL new_game_clear got %h exp 0", {square_en, square_color, player, game_over, winner, win_line}); end
  endtask

  task automatic test_reject;
    play(4, 0);
    n_checks++; if ({got_ack, got_rej} !== 2'b10) begin n_fail++; $display("FAIL first4 got %b exp 10", {got_ack, got_rej}); end
    play(4, 0);
    n_checks++; if ({got_ack, got_rej} !== 2'b01) begin n_fail++; $display("FAIL occupied got %b exp 01", {got_ack, got_rej}); end
    n_checks++; if ({square_en, square_color, player} !== {9'h010, 9'h000, 1'b1}) begin n_fail++; $display("FAIL occupied_board got %h exp %h", {square_en, square_color, player}, {9'h010, 9'h000, 1'b1}); end
    play(12, 0);
    n_checks++; if ({got_ack, got_rej, square_en} !== {2'b01, 9'h010}) begin n_fail++; $display("FAIL invalid_idx got %h exp %h", {got_ack, got_rej, square_en}, {2'b01, 9'h010}); end
    play(5, 1);
    n_checks++; if ({got_ack, got_rej, square_en, square_color} !== {2'b00, 9'h010, 9'h000}) begin n_fail++; $display("FAIL choice_drop got %h exp %h", {got_ack, got_rej, square_en, square_color}, {2'b00, 9'h010, 9'h000}); end
    play(5, 0);
    n_checks++; if ({got_ack, square_color} !== {1'b1, 9'h020}) begin n_fail++; $display("FAIL after_choice got %h exp %h", {got_ack, square_color}, {1'b1, 9'h020}); end
    pulse_new_game;
  endtask

  task automatic test_draw;
    int seq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    foreach (seq[i]) begin
      play(seq[i], 0);
      n_checks++; if (got_ack !== 1'b1) begin n_fail++; $display("FAIL draw_ack move %0d got %b exp 1", i, got_ack); end
    end
    n_checks++; if ({winner, win_line, game_over, square_en, square_color} !== {2'b11, 8'h00, 1'b1, 9'h1FF, 9'h072}) begin n_fail++; $display("FAIL draw_result got %h exp %h", {winner, win_line, game_over, square_en, square_color}, {2'b11, 8'h00, 1'b1, 9'h1FF, 9'h072}); end
    pulse_new_game;
    n_checks++; if ({square_en, player, winner, game_over} !== '0) begin n_fail++; $display("FAIL draw_new_game got %h exp 0", {square_en, player, winner, game_over}); end
    play(8, 0);
    n_checks++; if ({got_ack, square_en} !== {1'b1, 9'h100}) begin n_fail++; $display("FAIL wait_move_after_ng got %h exp %h", {got_ack, square_en}, {1'b1, 9'h100}); end
  endtask

  task automatic test_start_drop;
    play(0, 0);
    start_en = 0;
    tick;
    model_clear; idle = 1;
    n_checks++; if ({square_en, square_color, player, game_over} !== '0) begin n_fail++; $display("FAIL start_drop_clear got %h exp 0", {square_en, square_color, player, game_over}); end
    play(3, 0);
    n_checks++; if ({got_ack, got_rej, square_en} !== '0) begin n_fail++; $display("FAIL idle_drop got %h exp 0", {got_ack, got_rej, square_en}); end
    start_en = 1;
    tick;
    idle = 0;
    play(3, 0);
    n_checks++; if ({got_ack, square_en} !== {1'b1, 9'h008}) begin n_fail++; $display("FAIL restart got %h exp %h", {got_ack, square_en}, {1'b1, 9'h008}); end
    pulse_new_game;
  endtask

  task automatic test_new_game_priority;
    sel_idx = 4'd5; sel_valid = 1; new_game = 1;
    tick;
    sel_valid = 0; new_game = 0;
    n_checks++; if ({sel_ack, sel_reject, square_en} !== '0) begin n_fail++; $display("FAIL ng_vs_sel got %h exp 0", {sel_ack, sel_reject, square_en}); end
    sel_idx = 4'd6; sel_valid = 1;
    tick;
    sel_valid = 0; new_game = 1;
    tick;
    new_game = 0;
    n_checks++; if (square_en !== 9'h040) begin n_fail++; $display("FAIL ng_in_check_hold got %h exp 040", square_en); end
    tick;
    n_checks++; if ({square_en, player} !== 10'h0) begin n_fail++; $display("FAIL ng_pending got %h exp 0", {square_en, player}); end
    model_clear;
  endtask

  task automatic test_random;
    int idx;
    bit ch;
    for (int g = 0; g < 8; g++) begin
      pulse_new_game;
      for (int s = 0; s < 24; s++) begin
        idx = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 15));
        ch = ($urandom_range(0, 7) == 0);
        play(idx, ch);
        n_checks++; if ({got_ack, got_rej} !== {exp_ack, exp_rej}) begin n_fail++; $display("FAIL rnd_handshake g%0d s%0d idx %0d got %b exp %b", g, s, idx, {got_ack, got_rej}, {exp_ack, exp_rej}); end
        n_checks++; if ({square_en, square_color, player, game_over, winner, win_line} !== {m_en(), m_col(), 1'(turn), over, m_winner, m_line}) begin
          n_fail++; $display("FAIL rnd_state g%0d s%0d got %h exp %h", g, s, {square_en, square_color, player, game_over, winner, win_line}, {m_en(), m_col(), 1'(turn), over, m_winner, m_line});
        end
      end
    end
  endtask

  initial begin
    idle = 1;
    model_clear;
    test_reset;
    test_row_win;
    test_reject;
    test_draw;
    test_start_drop;
    test_new_game_priority;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
